// File: rtl/fpga_cfg_pkg.sv
// Shared types and helpers for the CRAM configuration loader.
// Optional CRC checking in cfg_loader is enabled with CFG_CRC_EN.
package fpga_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    SHIFT = 3'd2,
    CHK   = 3'd3,
    DONE  = 3'd4,
    ERROR = 3'd5
  } cfg_state_e;

  localparam logic [7:0] CFG_CRC8_POLY = 8'h07;

  // Number of input words needed to cover a chain of chain_len bits.
  function automatic int cfg_words(input int chain_len, input int word_w);
    return (chain_len + word_w - 1) / word_w;
  endfunction

endpackage

// File: rtl/cfg_crc8.sv
// Serial CRC-8 (MSB-first register, init 0), one bit per bit_en cycle.
// Used by cfg_loader only when CFG_CRC_EN is defined.
module cfg_crc8
  import fpga_cfg_pkg::*;
(
  input  logic       clk,
  input  logic       nrst,
  input  logic       clr,
  input  logic       bit_en,
  input  logic       bit_in,
  output logic [7:0] crc
);

  logic [7:0] r_crc;
  logic       w_fb;

  assign w_fb = r_crc[7] ^ bit_in;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)       r_crc <= 8'h00;
    else if (clr)    r_crc <= 8'h00;
    else if (bit_en) r_crc <= {r_crc[6:0], 1'b0} ^ (w_fb ? CFG_CRC8_POLY : 8'h00);
  end

  assign crc = r_crc;

endmodule

// File: rtl/cfg_loader.sv
// Serializes configuration words LSB-first into the head of the CRAM chain.
// Define CFG_CRC_EN to require a trailing CRC-8 word checked against the shifted bits.
module cfg_loader
  import fpga_cfg_pkg::*;
#(
  parameter int WORD_W    = 8,
  parameter int CHAIN_LEN = 20
) (
  input  logic                           clk,
  input  logic                           nrst,
  input  logic                           en,
  input  logic                           start,
  input  logic [WORD_W-1:0]              word_in,
  input  logic                           word_valid,
  output logic                           word_ready,
  output logic                           config_data_out,
  output logic                           config_en,
  output logic                           busy,
  output logic                           done,
  output logic                           crc_err,
  output logic [$clog2(CHAIN_LEN+1)-1:0] bits_left
);

  localparam int NWORDS = cfg_words(CHAIN_LEN, WORD_W);
  localparam int LAST_N = (CHAIN_LEN % WORD_W == 0) ? WORD_W : (CHAIN_LEN % WORD_W);
  localparam int BL_W   = $clog2(CHAIN_LEN + 1);
  localparam int CNT_W  = $clog2(WORD_W + 1);
  localparam int WC_W   = $clog2(NWORDS + 1);

  localparam logic [CNT_W-1:0] FULL_NB = CNT_W'(WORD_W);
  localparam logic [CNT_W-1:0] LAST_NB = CNT_W'(LAST_N);
  localparam logic [WC_W-1:0]  NW      = WC_W'(NWORDS);
  localparam logic [WC_W-1:0]  LASTW   = WC_W'(NWORDS - 1);
  localparam logic [BL_W-1:0]  BL_INIT = BL_W'(CHAIN_LEN);

  cfg_state_e        r_state;
  logic [WORD_W-1:0] r_sh;
  logic [CNT_W-1:0]  r_sh_cnt;
  logic [WORD_W-1:0] r_hold;
  logic              r_hold_vld;
  logic [CNT_W-1:0]  r_hold_n;
  logic [WC_W-1:0]   r_wacc;
  logic [BL_W-1:0]   r_bits_left;
  logic              r_dout;
  logic              r_cfg_en;
  logic              r_busy;
  logic              r_done;
  logic              r_crc_err;

  logic              w_ready;
  logic              w_xfer;
  logic              w_start;
  logic [CNT_W-1:0]  w_nbits;
  logic              w_crc_ok;

  always_comb begin
    w_ready = 1'b0;
    case (r_state)
      FILL, SHIFT: w_ready = en && !r_hold_vld && (r_wacc < NW);
`ifdef CFG_CRC_EN
      CHK:         w_ready = en && !r_hold_vld;
`endif
      default:     w_ready = 1'b0;
    endcase
  end

  assign w_xfer  = w_ready && word_valid;
  assign w_start = en && start && (r_state == IDLE || r_state == DONE || r_state == ERROR);
  // Only the last word of a non-multiple chain is partial; its upper bits are dropped.
  assign w_nbits = (r_wacc == LASTW) ? LAST_NB : FULL_NB;

`ifdef CFG_CRC_EN
  logic [7:0] w_crc;

  cfg_crc8 u_crc (
    .clk    (clk),
    .nrst   (nrst),
    .clr    (w_start),
    .bit_en (config_en),
    .bit_in (config_data_out),
    .crc    (w_crc)
  );

  assign w_crc_ok = (word_in[7:0] == w_crc);
`else
  assign w_crc_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state     <= IDLE;
      r_sh        <= '0;
      r_sh_cnt    <= '0;
      r_hold      <= '0;
      r_hold_vld  <= 1'b0;
      r_hold_n    <= '0;
      r_wacc      <= '0;
      r_bits_left <= BL_INIT;
      r_dout      <= 1'b0;
      r_cfg_en    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_crc_err   <= 1'b0;
    end else if (en) begin
      if (w_start) begin
        r_state     <= FILL;
        r_sh_cnt    <= '0;
        r_hold_vld  <= 1'b0;
        r_wacc      <= '0;
        r_bits_left <= BL_INIT;
        r_cfg_en    <= 1'b0;
        r_busy      <= 1'b1;
        r_done      <= 1'b0;
        r_crc_err   <= 1'b0;
      end else begin
        case (r_state)
          FILL, SHIFT: begin
            if (w_xfer) begin
              r_wacc  <= r_wacc + 1'b1;
              r_state <= SHIFT;
            end
            // Output bit source priority: shifter, then holding reg, then bypass of the new word.
            if (r_sh_cnt != '0) begin
              r_dout      <= r_sh[0];
              r_sh        <= r_sh >> 1;
              r_sh_cnt    <= r_sh_cnt - 1'b1;
              r_cfg_en    <= 1'b1;
              r_bits_left <= r_bits_left - 1'b1;
            end else if (r_hold_vld) begin
              r_dout      <= r_hold[0];
              r_sh        <= r_hold >> 1;
              r_sh_cnt    <= r_hold_n - 1'b1;
              r_hold_vld  <= 1'b0;
              r_cfg_en    <= 1'b1;
              r_bits_left <= r_bits_left - 1'b1;
            end else if (w_xfer) begin
              r_dout      <= word_in[0];
              r_sh        <= word_in >> 1;
              r_sh_cnt    <= w_nbits - 1'b1;
              r_cfg_en    <= 1'b1;
              r_bits_left <= r_bits_left - 1'b1;
            end else begin
              r_cfg_en    <= 1'b0;
            end
            if (w_xfer && r_sh_cnt != '0) begin
              r_hold     <= word_in;
              r_hold_vld <= 1'b1;
              r_hold_n   <= w_nbits;
            end
            // Leave SHIFT once the final bit has actually been presented for a cycle.
            if (r_state == SHIFT && r_bits_left == '0) begin
              r_cfg_en <= 1'b0;
`ifdef CFG_CRC_EN
              r_state  <= CHK;
`else
              r_state  <= DONE;
              r_done   <= 1'b1;
              r_busy   <= 1'b0;
`endif
            end
          end
`ifdef CFG_CRC_EN
          CHK: begin
            if (w_xfer) begin
              r_busy <= 1'b0;
              if (w_crc_ok) begin
                r_state <= DONE;
                r_done  <= 1'b1;
              end else begin
                r_state   <= ERROR;
                r_crc_err <= 1'b1;
              end
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

  assign word_ready      = w_ready;
  assign config_data_out = r_dout;
  assign config_en       = r_cfg_en && en;
  assign busy            = r_busy;
  assign done            = r_done;
  assign crc_err         = r_crc_err;
  assign bits_left       = r_bits_left;

endmodule

// File: tb/tb_cfg_loader.sv
// Scoreboard bench for cfg_loader (WORD_W=8, CHAIN_LEN=20); covers CRC paths when CFG_CRC_EN is defined.
module tb_cfg_loader;

  localparam int WORD_W    = 8;
  localparam int CHAIN_LEN = 20;

  logic              clk = 1'b0;
  logic              nrst = 1'b0;
  logic              en = 1'b1;
  logic              start = 1'b0;
  logic [WORD_W-1:0] word_in = '0;
  logic              word_valid = 1'b0;
  logic              word_ready, config_data_out, config_en, busy, done, crc_err;
  logic [4:0]        bits_left;

  int   n_chk = 0;
  int   n_fail = 0;
  int   bitcnt = 0;
  int   n_xfer = 0;
  int   gaps = 0;
  bit   seen_bit = 1'b0;
  bit   gap_chk = 1'b0;
  logic q[$];
  logic [7:0] exp_crc;

  cfg_loader #(.WORD_W(WORD_W), .CHAIN_LEN(CHAIN_LEN)) dut (
    .clk(clk), .nrst(nrst), .en(en), .start(start), .word_in(word_in),
    .word_valid(word_valid), .word_ready(word_ready), .config_data_out(config_data_out),
    .config_en(config_en), .busy(busy), .done(done), .crc_err(crc_err), .bits_left(bits_left)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
    return {c[6:0], 1'b0} ^ ((c[7] ^ b) ? 8'h07 : 8'h00);
  endfunction

  // Monitor: every shifted bit is popped from the scoreboard and compared.
  always @(negedge clk) begin
    if (nrst) begin
      if (word_valid && word_ready) n_xfer++;
      if (!en) begin
        chk("en0_cfg_en", config_en, 0);
        chk("en0_ready", word_ready, 0);
      end
      if (config_en) begin
        seen_bit = 1'b1;
        bitcnt++;
        if (q.size() == 0) chk("extra_bit", 1, 0);
        else chk("bit", config_data_out, q.pop_front());
      end else if (gap_chk && en && seen_bit && q.size() != 0) begin
        gaps++;
      end
    end
  end

  task automatic clr_counts();
    q.delete();
    bitcnt = 0; n_xfer = 0; gaps = 0; seen_bit = 1'b0; exp_crc = 8'h00;
  endtask

  task automatic do_reset();
    nrst = 1'b0; en = 1'b1; start = 1'b0; word_valid = 1'b0; word_in = '0;
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
    clr_counts();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic push_word(input logic [7:0] w, input int nb);
    for (int i = 0; i < nb; i++) begin
      q.push_back(w[i]);
      exp_crc = crc_step(exp_crc, w[i]);
    end
  endtask

  task automatic send_word(input logic [7:0] w, input bit toggle);
    bit got = 1'b0;
    word_in = w; word_valid = 1'b1;
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge clk); got = word_ready;
      @(posedge clk); #1;
    end
    if (!got) chk("xfer_timeout", 0, 1);
    word_valid = 1'b0;
    if (toggle) begin @(posedge clk); #1; end
  endtask

  task automatic wait_end();
    for (int k = 0; k < 300 && !(done || crc_err); k++) @(negedge clk);
    chk("end_reached", done | crc_err, 1);
    @(posedge clk); #1;
  endtask

  task automatic run_load(input bit toggle, input bit bad_crc);
    push_word(8'hA5, 8); push_word(8'h3C, 8); push_word(8'h0F, 4);
    pulse_start();
    chk("start_busy", busy, 1);
    chk("start_bits_left", bits_left, CHAIN_LEN);
    send_word(8'hA5, toggle);
    send_word(8'h3C, toggle);
    send_word(8'h0F, toggle);
`ifdef CFG_CRC_EN
    send_word(bad_crc ? (exp_crc ^ 8'h01) : exp_crc, toggle);
`endif
    wait_end();
  endtask

  task automatic check_ok(input string tag);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_crc_err"}, crc_err, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_bits"}, bitcnt, CHAIN_LEN);
    chk({tag, "_q_empty"}, q.size(), 0);
    chk({tag, "_bits_left"}, bits_left, 0);
  endtask

  initial begin
    int exp_x;
    bit bad;
    exp_x = 3;
`ifdef CFG_CRC_EN
    exp_x = 4;
`endif
    bad = 1'b0;

    // 1: reset values, then start with no words
    do_reset();
    @(negedge clk);
    chk("rst_ready", word_ready, 0);
    chk("rst_dout", config_data_out, 0);
    chk("rst_cfg_en", config_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_crc_err", crc_err, 0);
    chk("rst_bits_left", bits_left, CHAIN_LEN);
    @(posedge clk); #1;
    pulse_start();
    repeat (10) @(posedge clk);
    #1;
    chk("nowords_busy", busy, 1);
    chk("nowords_bits", bitcnt, 0);
    chk("nowords_bits_left", bits_left, CHAIN_LEN);

    // 2: continuous stream, no bubbles
    do_reset();
    gap_chk = 1'b1;
    run_load(1'b0, bad);
    chk("t2_gaps", gaps, 0);
    chk("t2_xfers", n_xfer, exp_x);
    check_ok("t2");
    // start after DONE begins a fresh load
    clr_counts();
    run_load(1'b0, bad);
    check_ok("t2b");
    gap_chk = 1'b0;

    // 3: en low for 5 cycles after bit 9
    do_reset();
    gap_chk = 1'b1;
    fork
      run_load(1'b0, bad);
      begin
        for (int k = 0; k < 300 && bitcnt < 9; k++) @(negedge clk);
        chk("t3_reach9", bitcnt >= 9, 1);
        @(posedge clk); #1 en = 1'b0;
        repeat (5) @(posedge clk);
        #1 en = 1'b1;
      end
    join
    chk("t3_gaps", gaps, 0);
    check_ok("t3");
    gap_chk = 1'b0;

    // 4: valid toggling
    do_reset();
    run_load(1'b1, bad);
    chk("t4_xfers", n_xfer, exp_x);
    check_ok("t4");

`ifdef CFG_CRC_EN
    // 5: wrong CRC, then restart clears error
    do_reset();
    run_load(1'b0, 1'b1);
    chk("t5_crc_err", crc_err, 1);
    chk("t5_done", done, 0);
    chk("t5_bits", bitcnt, CHAIN_LEN);
    pulse_start();
    chk("t5_clr_err", crc_err, 0);
    chk("t5_busy", busy, 1);
`endif

    // 6: reset after 10 bits, then clean reload
    do_reset();
    push_word(8'hA5, 8); push_word(8'h3C, 8);
    pulse_start();
    send_word(8'hA5, 1'b0);
    send_word(8'h3C, 1'b0);
    for (int k = 0; k < 300 && bitcnt < 10; k++) @(negedge clk);
    chk("t6_reach10", bitcnt >= 10, 1);
    do_reset();
    @(negedge clk);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_bits_left", bits_left, CHAIN_LEN);
    chk("t6_rst_cfg_en", config_en, 0);
    @(posedge clk); #1;
    run_load(1'b0, bad);
    check_ok("t6");

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
